// File: rtl/dram_port_arbiter.sv
// ----------------------------------------------------------------------------
// dram_port_arbiter
//
// Shares the single-port data RAM between four address pointers
// (bit0 GSP, bit1 RP, bit2 CP, bit3 STP) using request/acknowledge
// transactions and round-robin arbitration. Each access runs
// IDLE -> ISSUE -> (WAIT for reads) -> ACK -> IDLE.
//
// Ports:
//   Clk       in   system clock, rising edge
//   RST       in   synchronous active-high reset
//   req       in   [3:0]     per-requester request
//   we        in   [3:0]     per-requester write flag (1 = write)
//   ptr       in   [4*AW-1:0] per-requester address, requester i at [i*AW +: AW]
//   wdata     in   [4*DW-1:0] per-requester write data, requester i at [i*DW +: DW]
//   ack       out  [3:0]     one-cycle completion pulse to the granted requester
//   rdata     out  [DW-1:0]  read data, held until the next read completes
//   grant_id  out  [1:0]     current or last granted requester
//   busy      out            high whenever the FSM is not in IDLE
//   mem_addr  out  [AW-1:0]  DRAM address
//   mem_data  out  [DW-1:0]  DRAM write data
//   mem_wren  out            DRAM write enable (high for the ISSUE cycle only)
//   mem_q     in   [DW-1:0]  DRAM read data
// ----------------------------------------------------------------------------
module dram_port_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int READ_LAT = 1   // legal range 1..3
) (
    input  logic            Clk,
    input  logic            RST,
    input  logic [3:0]      req,
    input  logic [3:0]      we,
    input  logic [4*AW-1:0] ptr,
    input  logic [4*DW-1:0] wdata,
    output logic [3:0]      ack,
    output logic [DW-1:0]   rdata,
    output logic [1:0]      grant_id,
    output logic            busy,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_data,
    output logic            mem_wren,
    input  logic [DW-1:0]   mem_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t          state_q;
    logic [1:0]      last_grant_q;
    logic [1:0]      grant_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic            wren_q;
    logic [3:0]      ack_q;
    logic [DW-1:0]   rdata_q;
    logic [1:0]      cnt_q;

    // Round-robin pick: first requester with req high, scanning upward from
    // the one after last_grant and wrapping.
    logic [1:0]      pick_d;
    logic            found_d;
    logic [1:0]      scan_idx;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick_d   = '0;
        found_d  = 1'b0;
        scan_idx = '0;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = last_grant_q + 2'(k);  // k=4 wraps back to last_grant
            if (!found_d && req[scan_idx]) begin
                pick_d  = scan_idx;
                found_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        // NOTE: reset is synchronous and wins over everything; an aborted
        // transaction simply vanishes without an ack.
        if (RST) begin
            state_q      <= S_IDLE;
            last_grant_q <= 2'd3;   // GSP gets first pick after reset
            grant_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            wren_q       <= 1'b0;
            ack_q        <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        grant_q      <= pick_d;
                        last_grant_q <= pick_d;
                        addr_q       <= ptr[pick_d*AW +: AW];
                        data_q       <= wdata[pick_d*DW +: DW];
                        wren_q       <= we[pick_d];
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // wren_q doubles as the transaction's write flag here.
                    wren_q <= 1'b0;
                    if (wren_q) begin
                        ack_q   <= 4'b0001 << grant_q;
                        state_q <= S_ACK;
                    end else begin
                        cnt_q   <= 2'(READ_LAT);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        rdata_q <= mem_q;
                        ack_q   <= 4'b0001 << grant_q;
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != S_IDLE);
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign mem_wren = wren_q;

endmodule
